nios2_cpu_cpu_mult_combine: RTL and testbench
=============================================

# nios2_cpu_cpu_mult_combine

Downstream companion of the Nios II partial-product multiplier cell. Consumes the three registered 16x16 partial products (lo*lo, lo*hi, hi*lo) at the M stage and assembles the 32-bit MUL result for the A stage. When compiled in, it also produces the MULX high word for the unsigned, signed/unsigned and signed/signed variants. To do so it computes the missing hi*hi product with an iterative shift-add engine and stalls the pipeline until that result is ready.

## Interface
Parameters:
- none

Ports:
- clk  in  1  pipeline clock; all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- M_mul_cell_p1  in  32  src1[15:0]*src2[15:0], unsigned
- M_mul_cell_p2  in  32  src1[15:0]*src2[31:16], unsigned
- M_mul_cell_p3  in  32  src1[31:16]*src2[15:0], unsigned
- M_src1  in  32  full operand 1, stable while M_mul_stall=1
- M_src2  in  32  full operand 2, stable while M_mul_stall=1
- M_en  in  1  M-stage advance enable
- M_mul_req  in  1  multiply instruction present in M
- M_mul_op  in  2  0=MUL, 1=MULXUU, 2=MULXSU (src1 signed), 3=MULXSS
- A_mul_result  out  32  registered result
- A_mul_valid  out  1  one-cycle pulse: A_mul_result is valid
- M_mul_stall  out  1  hold M stage; combinational from state and request

## Operation
- A request is accepted when M_en, M_mul_req and the FSM is in IDLE are all 1.
- MUL (op 0):
  - A_mul_result <= p1 + ((p2 + p3) << 16), truncated to 32 bits.
  - A_mul_valid <= 1. No stall.
- MULX (op 1..3):
  - FSM: IDLE -> BUSY -> FIX -> IDLE.
  - On accept:
    - Capture p1, p2, p3, M_src1, M_src2 and op.
    - Load the multiplicand src1[31:16] and multiplier src2[31:16].
    - Clear the 32-bit accumulator and the 4-bit counter.
  - BUSY: each cycle, if the multiplier LSB is 1, add the shifted multiplicand to the accumulator. Then shift the multiplicand left and the multiplier right, and increment the counter. After 16 BUSY cycles (counter 15 -> wraps) go to FIX.
  - FIX:
    - Form the 64-bit sum: (acc << 32) + ((p2 + p3) << 16) + p1, with p2 + p3 kept at 33 bits and the carry preserved.
    - hi = sum[63:32].
    - op 2: subtract (src1[31] ? src2 : 0).
    - op 3: subtract (src1[31] ? src2 : 0) and (src2[31] ? src1 : 0).
    - All subtraction is mod 2^32.
    - Register hi to A_mul_result, pulse A_mul_valid, return to IDLE.
- M_mul_stall = (IDLE & M_en & M_mul_req & op != 0) | BUSY | FIX.
- M_en and M_mul_req are ignored outside IDLE.
- A_mul_valid is 0 in every cycle that no result is registered. A_mul_result holds its last value otherwise.

## Timing
- Reset values:
  - A_mul_result = 0, A_mul_valid = 0, M_mul_stall = 0.
  - FSM = IDLE, counter = 0, accumulator = 0.
- MUL accepted in cycle T: A_mul_valid = 1 in T+1. Back-to-back MULs give valid on consecutive cycles.
- MULX accepted in cycle T:
  - Stall is high in T..T+17.
  - BUSY in T+1..T+16, FIX in T+17.
  - A_mul_valid = 1 in T+18, stall low in T+18.
  - A new request may be accepted in T+18.
- Reset asserted mid-BUSY/FIX: abort immediately, no valid pulse, stall drops in the same cycle (asynchronous).
- A request with M_en = 0 is not accepted and produces neither stall nor valid.

## Configuration
- NIOS2_MUL_MULX_EN defined: the MULX FSM, shift-add engine and sign correction are present, as above.
- Undefined:
  - No FSM; M_mul_stall is tied 0.
  - Ops 1..3 complete in 1 cycle like MUL, with A_mul_result = 0 and A_mul_valid = 1.
  - M_src1 and M_src2 are unused.

## Test plan
- MUL, src1 = src2 = 0xFFFFFFFF (p1 = p2 = p3 = 0xFFFE0001) -> A_mul_result = 0x00000001 and valid at T+1, stall never high.
- MULXUU, same operands -> stall T..T+17, result 0xFFFFFFFE at T+18. MULXSU -> 0xFFFFFFFF. MULXSS -> 0x00000000.
- MULXUU, 0x00010000 * 0x00010000 (p1 = p2 = p3 = 0) -> result 0x00000001. Exercises the hi*hi path alone.
- Three back-to-back MULs, then a MULX with M_mul_req held during the stall -> valids at T+1..T+3, exactly one MULX valid, no duplicate accept.
- Reset pulse at T+5 of a MULX -> no valid, stall 0 immediately. A following MUL 3 * 5 (p1 = 15) returns 0x0000000F at +1.
- Build without NIOS2_MUL_MULX_EN, MULXSS request -> valid at T+1, result 0, stall 0.

Source files
------------

// File: rtl/nios2_cpu_cpu_mult_combine_if.sv
// Bundle between the M stage and the multiplier combine stage.
// The master drives partial products and operands; the slave returns result, valid and stall.
interface nios2_cpu_cpu_mult_combine_if;
  logic [31:0] M_mul_cell_p1;
  logic [31:0] M_mul_cell_p2;
  logic [31:0] M_mul_cell_p3;
  logic [31:0] M_src1;
  logic [31:0] M_src2;
  logic        M_en;
  logic        M_mul_req;
  logic [1:0]  M_mul_op;
  logic [31:0] A_mul_result;
  logic        A_mul_valid;
  logic        M_mul_stall;

  modport master (
    output M_mul_cell_p1, M_mul_cell_p2, M_mul_cell_p3,
    output M_src1, M_src2, M_en, M_mul_req, M_mul_op,
    input  A_mul_result, A_mul_valid, M_mul_stall
  );

  modport slave (
    input  M_mul_cell_p1, M_mul_cell_p2, M_mul_cell_p3,
    input  M_src1, M_src2, M_en, M_mul_req, M_mul_op,
    output A_mul_result, A_mul_valid, M_mul_stall
  );
endinterface

// File: rtl/nios2_cpu_cpu_mult_combine.sv
// Combines 16x16 partial products into MUL results; with NIOS2_MUL_MULX_EN defined it also
// computes the MULX high word via a 16-cycle shift-add hi*hi engine that stalls the M stage.
module nios2_cpu_cpu_mult_combine (
  input  logic clk,
  input  logic reset,
  nios2_cpu_cpu_mult_combine_if.slave mul_if
);

  logic [31:0] result_q;
  logic        valid_q;
  logic        accept;
  logic [31:0] mul_lo_m;

  // Only the low 16 bits of p2+p3 can reach the low result word.
  assign mul_lo_m = mul_if.M_mul_cell_p1
                  + {mul_if.M_mul_cell_p2[15:0] + mul_if.M_mul_cell_p3[15:0], 16'h0000};

  assign mul_if.A_mul_result = result_q;
  assign mul_if.A_mul_valid  = valid_q;

`ifdef NIOS2_MUL_MULX_EN

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] p1_q;
  logic [31:0] p2_q;
  logic [31:0] p3_q;
  logic [31:0] src1_q;
  logic [31:0] src2_q;
  logic [1:0]  op_q;
  logic [31:0] mcand_q;
  logic [15:0] mplier_q;
  logic [31:0] acc_q;
  logic [3:0]  cnt_q;
  logic [63:0] sum_d;
  logic [31:0] hi_d;
  logic [31:0] unused_sum_lo;

  assign accept = (state_q == S_IDLE) & mul_if.M_en & mul_if.M_mul_req;
  assign mul_if.M_mul_stall = (accept & (mul_if.M_mul_op != 2'd0)) | (state_q != S_IDLE);

  // Full 64-bit unsigned product; p2+p3 is kept at 33 bits so its carry reaches the high word.
  always_comb begin
    sum_d = {acc_q, 32'h0000_0000}
          + {15'h0000, {1'b0, p2_q} + {1'b0, p3_q}, 16'h0000}
          + {32'h0000_0000, p1_q};
    hi_d = sum_d[63:32];
    if (op_q[1] && src1_q[31]) begin
      hi_d = hi_d - src2_q;
    end
    if ((op_q == 2'd3) && src2_q[31]) begin
      hi_d = hi_d - src1_q;
    end
  end

  assign unused_sum_lo = sum_d[31:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      valid_q  <= 1'b0;
      p1_q     <= '0;
      p2_q     <= '0;
      p3_q     <= '0;
      src1_q   <= '0;
      src2_q   <= '0;
      op_q     <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (mul_if.M_mul_op == 2'd0) begin
              result_q <= mul_lo_m;
              valid_q  <= 1'b1;
            end else begin
              p1_q     <= mul_if.M_mul_cell_p1;
              p2_q     <= mul_if.M_mul_cell_p2;
              p3_q     <= mul_if.M_mul_cell_p3;
              src1_q   <= mul_if.M_src1;
              src2_q   <= mul_if.M_src2;
              op_q     <= mul_if.M_mul_op;
              mcand_q  <= {16'h0000, mul_if.M_src1[31:16]};
              mplier_q <= mul_if.M_src2[31:16];
              acc_q    <= '0;
              cnt_q    <= '0;
              state_q  <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          if (mplier_q[0]) begin
            acc_q <= acc_q + mcand_q;
          end
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 4'd1;
          if (cnt_q == 4'hF) begin
            state_q <= S_FIX;
          end
        end
        S_FIX: begin
          result_q <= hi_d;
          valid_q  <= 1'b1;
          state_q  <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

`else

  logic unused_src;

  assign accept             = mul_if.M_en & mul_if.M_mul_req;
  assign mul_if.M_mul_stall = 1'b0;
  assign unused_src         = ^{mul_if.M_src1, mul_if.M_src2};

  // Without the MULX engine, ops 1..3 retire immediately with a zero result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (accept) begin
        result_q <= (mul_if.M_mul_op == 2'd0) ? mul_lo_m : 32'h0000_0000;
        valid_q  <= 1'b1;
      end
    end
  end

`endif

endmodule

// File: tb/tb_nios2_cpu_cpu_mult_combine.sv
// Directed-vector bench for the multiplier combine stage; expectations adapt to
// whether NIOS2_MUL_MULX_EN is defined for the build.
module tb_nios2_cpu_cpu_mult_combine;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  nios2_cpu_cpu_mult_combine_if mif ();

  nios2_cpu_cpu_mult_combine dut (
    .clk    (clk),
    .reset  (reset),
    .mul_if (mif)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic req, input logic [1:0] op,
                       input logic [31:0] s1, input logic [31:0] s2,
                       input logic [31:0] p1, input logic [31:0] p2, input logic [31:0] p3);
    mif.M_en          = en;
    mif.M_mul_req     = req;
    mif.M_mul_op      = op;
    mif.M_src1        = s1;
    mif.M_src2        = s2;
    mif.M_mul_cell_p1 = p1;
    mif.M_mul_cell_p2 = p2;
    mif.M_mul_cell_p3 = p3;
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 2'd0, '0, '0, '0, '0, '0);
  endtask

  // MUL: valid one cycle after accept, never stalls.
  task automatic run_mul(input string tag, input logic [31:0] p1, input logic [31:0] p2,
                         input logic [31:0] p3, input logic [31:0] exp);
    drive(1'b1, 1'b1, 2'd0, '0, '0, p1, p2, p3);
    #1;
    check({tag, ".stall"}, {31'd0, mif.M_mul_stall}, 32'd0);
    tick();
    idle();
    #1;
    check({tag, ".valid"}, {31'd0, mif.A_mul_valid}, 32'd1);
    check({tag, ".result"}, mif.A_mul_result, exp);
    tick();
    check({tag, ".valid_drop"}, {31'd0, mif.A_mul_valid}, 32'd0);
    $display("MUL   %-12s p1=%08h p2=%08h p3=%08h -> %08h", tag, p1, p2, p3, mif.A_mul_result);
  endtask

  // MULX: stall T..T+17, valid T+18 (engine built in); otherwise behaves like a 1-cycle op with 0.
  task automatic run_mulx(input string tag, input logic [1:0] op,
                          input logic [31:0] s1, input logic [31:0] s2,
                          input logic [31:0] p1, input logic [31:0] p2, input logic [31:0] p3,
                          input logic [31:0] exp, input logic hold);
    drive(1'b1, 1'b1, op, s1, s2, p1, p2, p3);
`ifdef NIOS2_MUL_MULX_EN
    for (int k = 0; k < 18; k++) begin
      if (k == 1 && !hold) idle();
      #1;
      check($sformatf("%s.stall_T%0d", tag, k), {31'd0, mif.M_mul_stall}, 32'd1);
      if (k > 0) check($sformatf("%s.valid_T%0d", tag, k), {31'd0, mif.A_mul_valid}, 32'd0);
      tick();
    end
    idle();
    #1;
    check({tag, ".valid"}, {31'd0, mif.A_mul_valid}, 32'd1);
    check({tag, ".result"}, mif.A_mul_result, exp);
    check({tag, ".stall_done"}, {31'd0, mif.M_mul_stall}, 32'd0);
`else
    #1;
    check({tag, ".stall"}, {31'd0, mif.M_mul_stall}, 32'd0);
    tick();
    idle();
    #1;
    check({tag, ".valid"}, {31'd0, mif.A_mul_valid}, 32'd1);
    check({tag, ".result"}, mif.A_mul_result, 32'd0);
    check({tag, ".stall_done"}, {31'd0, mif.M_mul_stall}, 32'd0);
`endif
    tick();
    check({tag, ".valid_drop"}, {31'd0, mif.A_mul_valid}, 32'd0);
    check({tag, ".no_reaccept"}, {31'd0, mif.M_mul_stall}, 32'd0);
    $display("MULX  %-12s op=%0d src1=%08h src2=%08h -> %08h (model %08h)",
             tag, op, s1, s2, mif.A_mul_result, exp);
  endtask

  localparam logic [31:0] PFF = 32'hFFFE_0001;

  initial begin
    bit seen_valid;
    reset = 1'b1;
    idle();
    repeat (2) tick();
    check("rst.result", mif.A_mul_result, 32'd0);
    check("rst.valid", {31'd0, mif.A_mul_valid}, 32'd0);
    check("rst.stall", {31'd0, mif.M_mul_stall}, 32'd0);
    reset = 1'b0;
    tick();
    check("post_rst.valid", {31'd0, mif.A_mul_valid}, 32'd0);

    run_mul("mul_ff", PFF, PFF, PFF, 32'h0000_0001);
    run_mulx("mulxuu_ff", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, PFF, PFF, PFF, 32'hFFFF_FFFE, 1'b0);
    run_mulx("mulxsu_ff", 2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, PFF, PFF, PFF, 32'hFFFF_FFFF, 1'b0);
    run_mul("mul_ff2", PFF, PFF, PFF, 32'h0000_0001);
    run_mulx("mulxss_ff", 2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, PFF, PFF, PFF, 32'h0000_0000, 1'b0);
    run_mulx("mulxuu_hihi", 2'd1, 32'h0001_0000, 32'h0001_0000, '0, '0, '0, 32'h0000_0001, 1'b0);
    // 3 * -2: unsigned high word is 2; only the signed-src2 variant corrects it.
    run_mulx("mulxsu_3m2", 2'd2, 32'h0000_0003, 32'hFFFF_FFFE,
             32'h0002_FFFA, 32'h0002_FFFD, 32'h0, 32'h0000_0002, 1'b0);
    run_mulx("mulxss_3m2", 2'd3, 32'h0000_0003, 32'hFFFF_FFFE,
             32'h0002_FFFA, 32'h0002_FFFD, 32'h0, 32'hFFFF_FFFF, 1'b0);
    run_mulx("mulxss_m23", 2'd3, 32'hFFFF_FFFE, 32'h0000_0003,
             32'h0002_FFFA, 32'h0, 32'h0002_FFFD, 32'hFFFF_FFFF, 1'b0);

    // Back-to-back MULs followed by a MULX whose request stays asserted through the stall.
    drive(1'b1, 1'b1, 2'd0, '0, '0, PFF, PFF, PFF);
    tick();
    drive(1'b1, 1'b1, 2'd0, '0, '0, 32'h8, 32'h6, 32'h4);
    #1;
    check("b2b1.valid", {31'd0, mif.A_mul_valid}, 32'd1);
    check("b2b1.result", mif.A_mul_result, 32'h0000_0001);
    $display("MUL   b2b1         -> %08h", mif.A_mul_result);
    tick();
    drive(1'b1, 1'b1, 2'd0, '0, '0, 32'hF, 32'h0, 32'h0);
    #1;
    check("b2b2.valid", {31'd0, mif.A_mul_valid}, 32'd1);
    check("b2b2.result", mif.A_mul_result, 32'h000A_0008);
    $display("MUL   b2b2         -> %08h", mif.A_mul_result);
    tick();
    drive(1'b1, 1'b1, 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, PFF, PFF, PFF);
    #1;
    check("b2b3.valid", {31'd0, mif.A_mul_valid}, 32'd1);
    check("b2b3.result", mif.A_mul_result, 32'h0000_000F);
    $display("MUL   b2b3         -> %08h", mif.A_mul_result);
    run_mulx("b2b_mulx", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, PFF, PFF, PFF, 32'hFFFF_FFFE, 1'b1);

    // Reset in the middle of a MULX aborts it with no result.
    drive(1'b1, 1'b1, 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, PFF, PFF, PFF);
    tick();
    idle();
    repeat (4) tick();
    reset = 1'b1;
    #1;
    check("abort.stall", {31'd0, mif.M_mul_stall}, 32'd0);
    check("abort.valid", {31'd0, mif.A_mul_valid}, 32'd0);
    check("abort.result", mif.A_mul_result, 32'd0);
    tick();
    reset = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (mif.A_mul_valid || mif.M_mul_stall) seen_valid = 1'b1;
    end
    check("abort.quiet", {31'd0, seen_valid}, 32'd0);
    $display("ABORT reset mid-MULX -> stall=%0b valid=%0b", mif.M_mul_stall, mif.A_mul_valid);
    run_mul("mul_3x5", 32'd15, 32'd0, 32'd0, 32'h0000_000F);

    // M_en low: the request must be ignored entirely.
    drive(1'b0, 1'b1, 2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, PFF, PFF, PFF);
    #1;
    check("noen.stall", {31'd0, mif.M_mul_stall}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("noen.valid%0d", i), {31'd0, mif.A_mul_valid}, 32'd0);
      check($sformatf("noen.stall%0d", i), {31'd0, mif.M_mul_stall}, 32'd0);
    end
    check("noen.result_held", mif.A_mul_result, 32'h0000_000F);
    $display("NOEN  request with M_en=0 -> result %08h", mif.A_mul_result);
    idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
